mem_rw_pipe_helper: RTL and testbench



---
 rtl/mem_helper_pkg.sv | 40 ++++
 rtl/mem_rd_chan.sv | 83 ++++++++
 rtl/mem_rw_pipe_helper.sv | 78 +++++++
 tb/tb_mem_rw_pipe_helper.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_helper_pkg.sv
// Shared types, mask helper and RAM-model access functions for the memory
// read/write helper.
package mem_helper_pkg;

  localparam int BEAT_W = 64;

  typedef logic [63:0] beat_t;

  function automatic beat_t expand_mask(input logic [7:0] m);
    beat_t r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

`ifndef SYNTHESIS
  // Stand-in for the C++ RAM model: a sparse beat array plus a log of the
  // calls made, visible to whoever owns the sim.
  beat_t           ram_mem [longint unsigned];
  int unsigned     ram_rd_calls = 0;
  int unsigned     ram_wr_calls = 0;
  longint unsigned ram_wr_idx_q [$];
  beat_t           ram_wr_mask_q [$];

  function automatic beat_t ram_read(input longint unsigned idx);
    ram_rd_calls++;
    return ram_mem.exists(idx) ? ram_mem[idx] : '0;
  endfunction

  function automatic void ram_write(input longint unsigned idx,
                                    input beat_t data, input beat_t mask);
    beat_t old;
    old = ram_mem.exists(idx) ? ram_mem[idx] : '0;
    ram_mem[idx] = (old & ~mask) | (data & mask);
    ram_wr_calls++;
    ram_wr_idx_q.push_back(idx);
    ram_wr_mask_q.push_back(mask);
  endfunction
`endif

endpackage

// File: rtl/mem_rd_chan.sv
// One read channel: latency shift register, show-ahead response FIFO and
// outstanding-read credit counter.
module mem_rd_chan import mem_helper_pkg::*; #(
  parameter int DATA_W = 128,
  parameter int LAT    = 3,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              req_valid,
  output logic              req_ready,
  output logic              req_acc,
  input  logic [DATA_W-1:0] rd_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]     outst, cnt;
  logic [AW-1:0]     wptr, rptr;
  logic [LAT-1:0]    vld_pipe;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] last_d;
  logic              last_v, empty, pop, push, fifo_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign req_ready = enable && (outst < CW'(DEPTH));
  assign req_acc   = req_valid && req_ready;

  // rd_data is the capture register in the top, i.e. pipeline stage 1.
  if (LAT > 1) begin : g_dpipe
    logic [LAT-1:1][DATA_W-1:0] dat_pipe;
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) dat_pipe <= '0;
      else begin
        if (vld_pipe[0]) dat_pipe[1] <= rd_data;
        for (int k = 2; k < LAT; k++)
          if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
      end
    end
    assign last_d = dat_pipe[LAT-1];
  end else begin : g_nodpipe
    assign last_d = rd_data;
  end

  // Empty FIFO passes the last stage straight through, so the stage's
  // data register doubles as the "hold last value" output.
  assign last_v     = vld_pipe[LAT-1];
  assign empty      = (cnt == '0);
  assign resp_valid = !empty || last_v;
  assign resp_data  = empty ? last_d : mem[rptr];
  assign pop        = resp_valid && resp_ready;
  assign fifo_pop   = pop && !empty;
  assign push       = last_v && !(empty && resp_ready);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      outst    <= '0;
      cnt      <= '0;
      wptr     <= '0;
      rptr     <= '0;
    end else begin
      vld_pipe <= (vld_pipe << 1) | LAT'(req_acc);
      outst    <= outst + CW'(req_acc) - CW'(pop);
      cnt      <= cnt + CW'(push) - CW'(fifo_pop);
      if (push)     wptr <= nxt(wptr);
      if (fifo_pop) rptr <= nxt(rptr);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wptr] <= last_d;
  end

endmodule

// File: rtl/mem_rw_pipe_helper.sv
// Multi-channel memory access helper: NR read channels with fixed latency
// and credit flow control, one masked write channel, RAM model behind it.
module mem_rw_pipe_helper import mem_helper_pkg::*; #(
  parameter int NR     = 2,
  parameter int DATA_W = 128,
  parameter int LAT    = 3,
  parameter int DEPTH  = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [NR-1:0]              r_req_valid,
  output logic [NR-1:0]              r_req_ready,
  input  logic [NR-1:0][63:0]        r_req_index,
  output logic [NR-1:0]              r_resp_valid,
  input  logic [NR-1:0]              r_resp_ready,
  output logic [NR-1:0][DATA_W-1:0]  r_resp_data,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [63:0]                w_index,
  input  logic [DATA_W-1:0]          w_data,
  input  logic [DATA_W/8-1:0]        w_mask
);

  localparam int BEATS = DATA_W / BEAT_W;

  logic                      en;
  logic [NR-1:0]             r_acc;
  logic [NR-1:0][DATA_W-1:0] rd_q;

  assign en      = enable && reset_n;
  assign w_ready = en;

  for (genvar c = 0; c < NR; c++) begin : g_chan
    mem_rd_chan #(.DATA_W(DATA_W), .LAT(LAT), .DEPTH(DEPTH)) u_chan (
      .clock      (clock),
      .reset_n    (reset_n),
      .enable     (en),
      .req_valid  (r_req_valid[c]),
      .req_ready  (r_req_ready[c]),
      .req_acc    (r_acc[c]),
      .rd_data    (rd_q[c]),
      .resp_valid (r_resp_valid[c]),
      .resp_ready (r_resp_ready[c]),
      .resp_data  (r_resp_data[c])
    );
  end

  // All model calls live in this one block: reads in channel order, then
  // writes, so a same-edge read of a written index sees the old data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_q <= '0;
    end else begin
      for (int c = 0; c < NR; c++) begin
        if (r_acc[c]) begin
          for (int k = 0; k < BEATS; k++) begin
`ifndef SYNTHESIS
            rd_q[c][BEAT_W*k +: BEAT_W] <= ram_read(r_req_index[c] * 64'(BEATS) + 64'(k));
`else
            rd_q[c][BEAT_W*k +: BEAT_W] <= '0;
`endif
          end
        end
      end
`ifndef SYNTHESIS
      if (w_valid && en) begin
        for (int k = 0; k < BEATS; k++) begin
          if (|w_mask[8*k +: 8])
            ram_write(w_index * 64'(BEATS) + 64'(k), w_data[BEAT_W*k +: BEAT_W],
                      expand_mask(w_mask[8*k +: 8]));
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_rw_pipe_helper.sv
// Directed + random bench for mem_rw_pipe_helper against a word-level
// memory model and per-channel response scoreboards.
module tb_mem_rw_pipe_helper;
  import mem_helper_pkg::*;

  localparam int NR = 2, DATA_W = 128, LAT = 3, DEPTH = 4;
  localparam int BEATS = DATA_W / 64;

  logic                      clock = 1'b0;
  logic                      reset_n, enable;
  logic [NR-1:0]             r_req_valid, r_req_ready, r_resp_valid, r_resp_ready;
  logic [NR-1:0][63:0]       r_req_index;
  logic [NR-1:0][DATA_W-1:0] r_resp_data;
  logic                      w_valid, w_ready;
  logic [63:0]               w_index;
  logic [DATA_W-1:0]         w_data;
  logic [DATA_W/8-1:0]       w_mask;

  mem_rw_pipe_helper #(.NR(NR), .DATA_W(DATA_W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .r_req_valid(r_req_valid), .r_req_ready(r_req_ready), .r_req_index(r_req_index),
    .r_resp_valid(r_resp_valid), .r_resp_ready(r_resp_ready), .r_resp_data(r_resp_data),
    .w_valid(w_valid), .w_ready(w_ready), .w_index(w_index), .w_data(w_data), .w_mask(w_mask)
  );

  always #5 clock = ~clock;

  typedef struct { logic [DATA_W-1:0] d; int due; } rsp_t;
  rsp_t              exp_q [NR][$];
  logic [DATA_W-1:0] ref_mem [longint];
  int n_chk = 0, n_fail = 0, cyc_n = 0, acc_cnt = 0;

  localparam logic [DATA_W-1:0] P2 = 128'h01234567_89abcdef_fedcba98_76543210;
  localparam logic [DATA_W-1:0] P5 = {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
  localparam logic [DATA_W-1:0] P7 = {16{8'h77}};

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mdl_rd(input longint i);
    return ref_mem.exists(i) ? ref_mem[i] : '0;
  endfunction

  task automatic mdl_wr(input longint i, input logic [DATA_W-1:0] d, input logic [DATA_W/8-1:0] m);
    logic [DATA_W-1:0] v;
    v = mdl_rd(i);
    for (int b = 0; b < DATA_W/8; b++) if (m[b]) v[8*b +: 8] = d[8*b +: 8];
    ref_mem[i] = v;
  endtask

  task automatic preload(input int i, input logic [DATA_W-1:0] v);
    ref_mem[longint'(i)] = v;
    for (int k = 0; k < BEATS; k++) ram_mem[64'(i * BEATS + k)] = v[64*k +: 64];
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model by the
  // handshakes that the coming edge performs.
  task automatic cyc();
    logic [NR-1:0] rdy_e, vld_e;
    rsp_t e;
    #3;
    for (int c = 0; c < NR; c++) begin
      rdy_e[c] = enable && reset_n && (exp_q[c].size() < DEPTH);
      vld_e[c] = (exp_q[c].size() > 0) && (exp_q[c][0].due <= cyc_n);
      chk($sformatf("req_ready%0d@%0d", c, cyc_n), r_req_ready[c], rdy_e[c]);
      chk($sformatf("resp_valid%0d@%0d", c, cyc_n), r_resp_valid[c], vld_e[c]);
      if (vld_e[c]) chk($sformatf("resp_data%0d@%0d", c, cyc_n), r_resp_data[c], exp_q[c][0].d);
    end
    chk($sformatf("w_ready@%0d", cyc_n), w_ready, enable && reset_n);
    if (r_req_valid[0] && r_req_ready[0]) acc_cnt++;
    for (int c = 0; c < NR; c++) if (vld_e[c] && r_resp_ready[c]) void'(exp_q[c].pop_front());
    for (int c = 0; c < NR; c++)
      if (r_req_valid[c] && rdy_e[c]) begin
        e.d = mdl_rd(longint'(r_req_index[c]));
        e.due = cyc_n + LAT;
        exp_q[c].push_back(e);
      end
    if (w_valid && enable && reset_n) mdl_wr(longint'(w_index), w_data, w_mask);
    @(posedge clock); #1;
    cyc_n++;
  endtask

  task automatic idle(input int n);
    r_req_valid = '0; w_valid = 1'b0; r_resp_ready = '1;
    repeat (n) cyc();
  endtask

  task automatic rd1(input int c, input int idx);
    r_req_valid[c] = 1'b1; r_req_index[c] = 64'(idx);
    cyc();
    r_req_valid[c] = 1'b0;
  endtask

  initial begin
    int unsigned rc, wc;
    int a0;
    reset_n = 1'b0; enable = 1'b1;
    r_req_valid = '0; r_req_index = '0; r_resp_ready = '1;
    w_valid = 1'b0; w_index = '0; w_data = '0; w_mask = '0;
    for (int i = 0; i < 16; i++) preload(i, {32'(i), $urandom, $urandom, $urandom});
    preload(2, P2); preload(5, P5); preload(7, P7);

    #2;
    chk("rst_req_ready", r_req_ready, '0);
    chk("rst_resp_valid", r_resp_valid, '0);
    chk("rst_resp_data0", r_resp_data[0], '0);
    chk("rst_resp_data1", r_resp_data[1], '0);
    chk("rst_w_ready", w_ready, '0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // basic read: valid exactly LAT cycles after accept, two beat reads
    idle(2);
    rc = ram_rd_calls;
    rd1(0, 5);
    repeat (LAT - 1) cyc();
    #1 chk("basic_data", r_resp_data[0], P5);
    chk("basic_valid", r_resp_valid[0], 1'b1);
    idle(2);
    chk("basic_rd_calls", 128'(ram_rd_calls - rc), 128'(BEATS));

    // backpressure: six back-to-back requests, four credits
    r_resp_ready[0] = 1'b0; a0 = acc_cnt;
    for (int i = 0; i < 6; i++) begin
      r_req_valid[0] = 1'b1; r_req_index[0] = 64'(i);
      cyc();
    end
    r_req_valid[0] = 1'b0;
    chk("bp_accepted", 128'(acc_cnt - a0), 128'd4);
    chk("bp_ready_low", r_req_ready[0], 1'b0);
    r_resp_ready[0] = 1'b1;
    cyc();
    r_resp_ready[0] = 1'b0;
    chk("bp_ready_back", r_req_ready[0], 1'b1);
    cyc();
    idle(6);

    // masked write: only beat 1 low half touched
    wc = ram_wr_calls;
    w_valid = 1'b1; w_index = 64'd2; w_data = {16{8'h11}}; w_mask = 16'h0F00;
    cyc();
    w_valid = 1'b0;
    chk("wr_calls", 128'(ram_wr_calls - wc), 128'd1);
    chk("wr_idx", 128'(ram_wr_idx_q[$]), 128'd5);
    chk("wr_mask", 128'(ram_wr_mask_q[$]), 128'h00000000FFFFFFFF);
    rd1(0, 2);
    repeat (LAT - 1) cyc();
    #1 chk("wr_readback", r_resp_data[0], 128'h01234567_11111111_fedcba98_76543210);
    idle(2);

    // collision: same-edge read sees old data, later read sees new
    r_req_valid[1] = 1'b1; r_req_index[1] = 64'd7;
    w_valid = 1'b1; w_index = 64'd7; w_data = '1; w_mask = '1;
    cyc();
    r_req_valid[1] = 1'b0; w_valid = 1'b0;
    repeat (LAT - 1) cyc();
    #1 chk("coll_old", r_resp_data[1], P7);
    idle(2);
    rd1(1, 7);
    repeat (LAT - 1) cyc();
    #1 chk("coll_new", r_resp_data[1], '1);
    idle(2);

    // reset with three reads in flight
    for (int i = 0; i < 3; i++) begin
      r_req_valid[0] = 1'b1; r_req_index[0] = 64'(8 + i);
      cyc();
    end
    r_req_valid[0] = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", r_req_ready, '0);
    chk("mid_rst_resp_valid", r_resp_valid, '0);
    chk("mid_rst_resp_data0", r_resp_data[0], '0);
    chk("mid_rst_w_ready", w_ready, '0);
    for (int c = 0; c < NR; c++) exp_q[c].delete();
    @(posedge clock); #1;
    cyc_n++;
    reset_n = 1'b1;
    r_resp_ready[0] = 1'b0; a0 = acc_cnt;
    for (int i = 0; i < 4; i++) begin
      r_req_valid[0] = 1'b1; r_req_index[0] = 64'(i);
      cyc();
    end
    chk("post_rst_accepted", 128'(acc_cnt - a0), 128'd4);
    idle(8);

    // enable drop with two reads in flight
    rd1(0, 3);
    rd1(1, 4);
    enable = 1'b0; r_req_valid = '1;
    w_valid = 1'b1; w_index = 64'd9; w_data = '0; w_mask = '1;
    #1;
    chk("en_req_ready", r_req_ready, '0);
    chk("en_w_ready", w_ready, 1'b0);
    repeat (4) cyc();
    enable = 1'b1;
    idle(2);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      enable = ($urandom_range(9) != 0);
      for (int c = 0; c < NR; c++) begin
        r_req_valid[c]  = 1'($urandom_range(1));
        r_req_index[c]  = 64'($urandom_range(15));
        r_resp_ready[c] = ($urandom_range(3) != 0);
      end
      w_valid = ($urandom_range(4) == 0);
      w_index = 64'($urandom_range(15));
      w_data  = {$urandom, $urandom, $urandom, $urandom};
      w_mask  = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom);
      cyc();
    end
    enable = 1'b1;
    idle(LAT + DEPTH + 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
